// File: rtl/dm_responder.sv
// Data-memory responder: turns single-cycle core load/store requests into a
// multi-cycle SRAM access, stalling the core until the access completes.
module dm_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DM_WEB,
    input  logic                  DM_write,
    input  logic [3:0]            DM_BWEB,
    input  logic [31:0]           DM_addr,
    input  logic [31:0]           DM_DI,
    output logic [31:0]           DM_DO,
    output logic                  DM_stall,
    output logic                  dm_err,
    output logic                  sram_CEB,
    output logic                  sram_WEB,
    output logic [3:0]            sram_BWEB,
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic [31:0]           sram_DI,
    input  logic [31:0]           sram_DO
);

    localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           do_q, do_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [3:0]            cmd_bweb_q, cmd_bweb_d;
    logic [31:0]           cmd_di_q, cmd_di_d;
    logic                  cmd_write_q, cmd_write_d;

    logic req;
    logic in_range;
    logic in_access;

    assign req       = DM_WEB | DM_write;
    assign in_range  = (DM_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    assign in_access = (state_q == StAccess);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        do_d        = do_q;
        err_d       = 1'b0;
        cmd_addr_d  = cmd_addr_q;
        cmd_bweb_d  = cmd_bweb_q;
        cmd_di_d    = cmd_di_q;
        cmd_write_d = cmd_write_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (in_range) begin
                        cmd_addr_d  = DM_addr[ADDR_WIDTH+1:2];
                        cmd_bweb_d  = DM_BWEB;
                        cmd_di_d    = DM_DI;
                        cmd_write_d = DM_write;  // write wins over a simultaneous read
                        cnt_d       = WaitCnt;
                        state_d     = StAccess;
                    end else begin
                        // Out-of-range: skip the SRAM, report an error in DONE
                        err_d   = 1'b1;
                        state_d = StDone;
                        if (!DM_write) begin
                            do_d = 32'd0;
                        end
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!cmd_write_q) begin
                        do_d = sram_DO;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            do_q        <= 32'd0;
            err_q       <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_bweb_q  <= 4'hF;
            cmd_di_q    <= 32'd0;
            cmd_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            do_q        <= do_d;
            err_q       <= err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_bweb_q  <= cmd_bweb_d;
            cmd_di_q    <= cmd_di_d;
            cmd_write_q <= cmd_write_d;
        end
    end

    // Stall is gated by reset so a held request cannot stall the core while in reset
    assign DM_stall  = rst & ((state_q == StIdle && req) || in_access);
    assign sram_CEB  = ~in_access;
    assign sram_WEB  = ~(in_access && cmd_write_q && (cnt_q == WaitCnt));
    assign sram_BWEB = in_access ? cmd_bweb_q : 4'hF;
    assign sram_A    = cmd_addr_q;
    assign sram_DI   = cmd_di_q;
    assign DM_DO     = do_q;
    assign dm_err    = err_q;

endmodule
